// File: rtl/transmitting.sv
// transmitting: serial character transmitter.
// Sends each accepted byte as a 10-bit frame: start bit 0, 8 data bits LSB
// first, stop bit 1. Each bit is held for BIT_TICKS clocks.
// Optional macro TX_BUFFER_EN adds a one-entry holding register so that
// frames can be sent back to back with no idle clock between them.
module transmitting #(
  parameter int BIT_TICKS = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       load,
  output logic       ready,
  output logic       busy,
  output logic       data_out,
  output logic       charSent
);

  localparam int CW = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(BIT_TICKS - 1);
  localparam logic [CW-1:0] PRE  = CW'(BIT_TICKS - 2);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state, state_nxt;
  logic [9:0]      shreg;      // shreg[0] is the line; idles all ones
  logic [CW-1:0]   tick;
  logic [3:0]      bit_idx;    // 0 start, 1..8 data, 9 stop
  logic            busy_q;
  logic            sent_q;
  logic            accept;
  logic            bit_end;
  logic            start_frame;
  logic [7:0]      start_char;

`ifdef TX_BUFFER_EN
  logic [7:0] hold;
  logic       pending;
  assign ready = !pending;
`else
  assign ready = (state == IDLE);
`endif

  assign accept   = load && ready;
  assign bit_end  = (tick == LAST);
  assign data_out = shreg[0];
  assign busy     = busy_q;
  assign charSent = sent_q;

  // Next-state decode; start_frame marks the edge a new frame is latched.
  always_comb begin
    state_nxt   = state;
    start_frame = 1'b0;
    start_char  = data_in;
    case (state)
      IDLE: begin
`ifdef TX_BUFFER_EN
        if (pending) begin
          start_frame = 1'b1;
          start_char  = hold;
          state_nxt   = START;
        end else
`endif
        if (accept) begin
          start_frame = 1'b1;
          state_nxt   = START;
        end
      end
      START: if (bit_end) state_nxt = DATA;
      DATA:  if (bit_end && bit_idx == 4'd8) state_nxt = STOP;
      STOP: begin
        if (bit_end) begin
          state_nxt = IDLE;
`ifdef TX_BUFFER_EN
          // Chain straight into the next start bit when a byte is waiting.
          if (pending) begin
            start_frame = 1'b1;
            start_char  = hold;
            state_nxt   = START;
          end else if (accept) begin
            start_frame = 1'b1;
            state_nxt   = START;
          end
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, shift register, counters and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      shreg   <= '1;
      tick    <= '0;
      bit_idx <= '0;
      busy_q  <= 1'b0;
      sent_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      // Raised one clock early so the pulse lands on the last stop clock.
      sent_q <= (state == STOP) && (tick == PRE);
      if (start_frame) begin
        shreg   <= {1'b1, start_char, 1'b0};
        tick    <= '0;
        bit_idx <= '0;
        busy_q  <= 1'b1;
      end else if (state != IDLE) begin
        if (bit_end) begin
          tick    <= '0;
          shreg   <= {1'b1, shreg[9:1]};
          bit_idx <= (bit_idx == 4'd9) ? 4'd0 : bit_idx + 4'd1;
          if (state == STOP) busy_q <= 1'b0;
        end else begin
          tick <= tick + 1'b1;
        end
      end
    end
  end

`ifdef TX_BUFFER_EN
  // Holding register: filled by loads that cannot start a frame right away.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold    <= '0;
      pending <= 1'b0;
    end else if (start_frame && pending) begin
      pending <= 1'b0;
    end else if (accept && !start_frame) begin
      hold    <= data_in;
      pending <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_transmitting.sv
// Directed bench for transmitting (BIT_TICKS = 16).
module tb_transmitting;
  localparam int BT = 16;
  localparam int FL = 10 * BT;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       load;
  logic       ready, busy, data_out, charSent;

  int vectors = 0;
  int errors  = 0;

  transmitting #(.BIT_TICKS(BT)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .load(load),
    .ready(ready), .busy(busy), .data_out(data_out), .charSent(charSent)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks one whole frame starting in cycle N+1. ready is expected high for
  // loop index < rdy_until. A load of inj_d is offered at edge N+inj_at.
  task automatic run_frame(input string tag, input logic [9:0] fr, input int rdy_until,
                           input int inj_at, input logic [7:0] inj_d);
    for (int i = 0; i < FL; i++) begin
      chk({tag, " data_out"}, 32'(data_out), 32'(fr[i / BT]));
      chk({tag, " busy"},     32'(busy),     32'd1);
      chk({tag, " charSent"}, 32'(charSent), 32'(i == FL - 1));
      chk({tag, " ready"},    32'(ready),    32'(i < rdy_until));
      if (i == inj_at - 1) begin
        load    = 1'b1;
        data_in = inj_d;
      end else begin
        load = 1'b0;
      end
      step();
    end
    load = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, " data_out"}, 32'(data_out), 32'd1);
    chk({tag, " busy"},     32'(busy),     32'd0);
    chk({tag, " charSent"}, 32'(charSent), 32'd0);
    chk({tag, " ready"},    32'(ready),    32'd1);
  endtask

  task automatic start_load(input logic [7:0] d);
    data_in = d;
    load    = 1'b1;
    step();
    load    = 1'b0;
  endtask

`ifdef TX_BUFFER_EN
  localparam int RDY_BUSY = FL;
`else
  localparam int RDY_BUSY = 0;
`endif

  initial begin
    reset   = 1'b1;
    load    = 1'b0;
    data_in = 8'h00;
    step();
    step();
    reset = 1'b0;
    check_idle("reset");

    // 50 idle clocks with garbage on data_in and no load.
    for (int i = 0; i < 50; i++) begin
      data_in = 8'(i * 7);
      step();
      check_idle("idle");
    end

    // 0xA5: line pattern 0,1,0,1,0,0,1,0,1,1 (LSB first)
    start_load(8'hA5);
    run_frame("a5", 10'b11_0100_1010, RDY_BUSY, -1, 8'h00);
    check_idle("a5 end");

    // All-zero and all-one data
    start_load(8'h00);
    run_frame("x00", 10'b10_0000_0000, RDY_BUSY, -1, 8'h00);
    check_idle("x00 end");
    start_load(8'hFF);
    run_frame("xff", 10'b11_1111_1110, RDY_BUSY, -1, 8'h00);
    check_idle("xff end");

    // Reset sampled at edge N+70 of a 0x3C frame.
    start_load(8'h3C);
    for (int i = 0; i < 69; i++) begin
      chk("x3c data_out", 32'(data_out), 32'(((10'b10_0111_1000) >> (i / BT)) & 10'd1));
      step();
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_idle("abort");
    for (int i = 0; i < FL; i++) begin
      step();
      check_idle("after abort");
    end
    start_load(8'h81);
    run_frame("x81", 10'b11_0000_0010, RDY_BUSY, -1, 8'h00);
    check_idle("x81 end");

    // Reset and load together: reset wins.
    reset   = 1'b1;
    load    = 1'b1;
    data_in = 8'h55;
    step();
    reset = 1'b0;
    load  = 1'b0;
    check_idle("rst+load");
    step();
    check_idle("rst+load next");

`ifdef TX_BUFFER_EN
    // 0x12 then 0x34 at N+5: back-to-back frames, zero idle clocks.
    start_load(8'h12);
    run_frame("buf 12", 10'b10_0010_0100, 5, 5, 8'h34);
    run_frame("buf 34", 10'b10_0110_1000, FL, -1, 8'h00);
    check_idle("buf end");
`else
    // 0x12 then 0x34 at N+50: second load ignored.
    start_load(8'h12);
    run_frame("nobuf 12", 10'b10_0010_0100, 0, 50, 8'h34);
    check_idle("nobuf end");
    for (int i = 0; i < 2 * BT; i++) begin
      step();
      check_idle("nobuf idle");
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/transmitting.md
# transmitting

Serial character transmitter: the transmit-side counterpart of the character receive path. Accepts an 8-bit character through a load/ready handshake and shifts it out on a single line as a 10-bit frame: start bit 0, 8 data bits LSB first, stop bit 1. Each bit is held for BIT_TICKS clocks, matching the receiver's 16-tick bit sampling, so a receiver on the same clock recovers the frame exactly. Sits between the processor-side character source and the serial output pin.

## Interface
- BIT_TICKS, 16, clocks per bit period; legal range 2..256
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-high; clears all state
- data_in  input  8  character to send; sampled only on an accepted load
- load  input  1  request to send data_in; accepted on any edge where load && ready
- ready  output  1  block can accept a character this cycle
- busy  output  1  a frame is being driven on data_out
- data_out  output  1  serial line; idles high
- charSent  output  1  one-cycle pulse in the last clock of each stop bit

## Operation
- Registers: 10-bit frame shift register (PISO), bit-tick counter ceil(log2(BIT_TICKS)) bits, 4-bit bit index 0..9, FSM.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: data_out=1, busy=0. Accepted load (or pending holding register, see Configuration) → START; latch frame {1, data_in, 0}.
  - START: data_out=0 for BIT_TICKS clocks → DATA, bit index 1.
  - DATA: data_out = data bit (index−1), LSB first; each bit BIT_TICKS clocks; after bit 8 → STOP.
  - STOP: data_out=1 for BIT_TICKS clocks; charSent=1 in final clock. Then: next character available → START (no idle gap), else → IDLE.
- Tick counter counts 0..BIT_TICKS−1, wraps to 0 on bit advance; bit index never exceeds 9.
- data_out, busy, charSent are registered (no combinational path from load).
- load while ready=0 ignored; data_in not sampled.
- Reset mid-frame: frame aborted, data_out=1 the cycle after reset is sampled, no charSent pulse, pending character discarded.

## Timing
- Reset values: data_out=1, busy=0, charSent=0, ready=1, FSM=IDLE, counters=0.
- Load accepted at edge N → data_out=0 and busy=1 from cycle N+1.
- Frame duration exactly 10×BIT_TICKS clocks: start bit cycles N+1..N+BIT_TICKS, data bit k cycles N+1+(k+1)×BIT_TICKS .. N+(k+2)×BIT_TICKS.
- charSent high in cycle N+10×BIT_TICKS only.
- busy falls cycle N+10×BIT_TICKS+1 if nothing pending; otherwise stays 1 and data_out=0 (next start) that cycle.
- Without buffer: ready = (FSM==IDLE); minimum frame-to-frame spacing 1 idle clock (load sampled in IDLE).
- Simultaneous reset and load: reset wins; load ignored.

## Configuration
- TX_BUFFER_EN defined: one-entry 8-bit holding register. ready = holding register empty. Load accepted during a frame fills it; at the end of STOP its contents enter the shift register and START begins the next cycle (back-to-back frames, zero idle). Load accepted in IDLE with empty holding register bypasses it (same N+1 start timing). Holding register and pending flag cleared by reset.
- TX_BUFFER_EN undefined: no holding register; ready = (FSM==IDLE); loads during busy ignored.

## Test plan
- Reset then idle 50 clocks → data_out=1, busy=0, ready=1, charSent never high.
- BIT_TICKS=16, load 0xA5 at edge N → data_out 16-clock bits 0,1,0,1,0,0,1,0,1,1 starting N+1; charSent only at N+160; busy=0 at N+161.
- Send 0x00 and 0xFF → eight data-bit periods all 0 / all 1, start=0, stop=1, each frame exactly 160 clocks.
- Reset asserted at cycle N+70 of 0x3C frame → data_out=1 next cycle, no charSent, busy=0, next load 0x81 sends a clean frame.
- Without TX_BUFFER_EN: load 0x12 then pulse load 0x34 at N+50 → 0x34 ignored, ready=0 until N+161, only 0x12 sent.
- With TX_BUFFER_EN: load 0x12 at N, load 0x34 at N+5 → ready=0 from N+6, 0x34 start bit begins N+161 with no idle cycle, two charSent pulses at N+160 and N+320.
